onchip_memory_test_master: RTL and testbench
============================================

Name: onchip_memory_test_master

Overview:
- Avalon-MM master that drives the single-port on-chip RAM slave (13-bit word address, 32-bit data, 4-bit byteenable, clken, read latency 1).
- On a start pulse it writes a deterministic pattern over a word region, then reads the region back, pipelined one word per cycle, and compares each word.
- It reports the mismatch count and the first failing address.
- Sits beside the Nios II as a built-in memory self-test; the RAM slave port is muxed to it while busy is high.

Parameters:
- ADDR_W, 13, word address width of the RAM slave.
- DATA_W, 32, data width; must be a multiple of 8.
- DEPTH, 6500, number of implemented words; addresses wrap modulo DEPTH.
- ERR_W, 16, error counter width (saturating).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled at start.
- length  in  ADDR_W+1  word count; sampled at start.
- seed  in  DATA_W  pattern seed; sampled at start.
- abort  in  1  level; ends the test early.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  valid with done; test was cut short.
- error_count  out  ERR_W  mismatches, saturating at all-ones.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_valid  out  1  first_err_addr is meaningful.
- m_address  out  ADDR_W  to RAM address.
- m_byteenable  out  DATA_W/8  to RAM byteenable; always all-ones.
- m_chipselect  out  1  to RAM chipselect.
- m_write  out  1  to RAM write.
- m_writedata  out  DATA_W  to RAM writedata.
- m_clken  out  1  to RAM clken; tied to 1.
- m_readdata  in  DATA_W  from RAM readdata.

Behaviour:
- Reset: state IDLE. busy, done, aborted, m_chipselect, m_write = 0. error_count, first_err_addr, first_err_valid, m_address, m_writedata = 0. m_byteenable = all-ones, m_clken = 1.
- Sampling at an accepted start: len_eff = min(length, DEPTH); base_eff = base_addr mod DEPTH.
- Counters cleared at an accepted start: error_count, first_err_valid.
- Pattern for word offset i: P(i) = seed + i, modulo 2^DATA_W.
- Addressing: word i uses address A(i) = (base_eff + i) mod DEPTH. Wrap is done with an incrementing pointer reset to 0 when it equals DEPTH-1; no divider.
- All m_* outputs are registered.
- State IDLE:
  - start=1 and len_eff=0: done=1 next cycle; busy never rises; counts are 0.
  - start=1 and len_eff>0: go to WRITE.
- State WRITE: one write per cycle with chipselect=1, write=1, address=A(i), writedata=P(i), for i = 0..len_eff-1. After the last write go to READ.
- State READ: one read per cycle with chipselect=1, write=0, address=A(i), for i = 0..len_eff-1. After the last issue go to FLUSH.
- Compare timing: read data for the address presented at cycle t is sampled from m_readdata at t+1. A 1-deep pipeline register carries the expected P(i), A(i) and a valid bit.
- Compare result on mismatch:
  - error_count increments, saturating.
  - If first_err_valid=0: first_err_addr = A(i) and first_err_valid = 1.
- State FLUSH: one cycle with chipselect=0 that compares the final word. Then done=1 and busy=0, and the state returns to IDLE.
- Test duration: 2*len_eff + 2 cycles from start to done.
- abort=1 in WRITE or READ:
  - Stop issuing and deassert chipselect/write next cycle.
  - A read already in flight is still compared.
  - Then go via FLUSH to done with aborted=1.
- abort in IDLE: ignored.
- start while busy: ignored.
- Reset mid-test: all outputs return to reset values next cycle. No done pulse. RAM contents are not restored.
- Status retention: error_count and first_err_* hold until the next accepted start.

Test Plan:
- Reset, start base=0, len=16, seed=0x1000_0000 with ideal RAM model → 16 writes with data 0x1000_0000..0x1000_000F; done exactly 34 cycles after start; error_count=0, first_err_valid=0.
- RAM model with a stuck bit0 forced low at address 5, start base=0, len=8, seed=0 → error_count=1, first_err_addr=5.
- Wrap: base=6498, len=4, seed=7 → addresses 6498, 6499, 0, 1 with data 7, 8, 9, 10; error_count=0.
- Boundaries: len=0 → done 1 cycle after start, busy stays 0. len=8000 → clamped to 6500, done after 13002 cycles.
- Abort asserted on the 3rd READ cycle of a len=10 run → chipselect drops next cycle; done with aborted=1; only the 3 issued reads are compared.
- Reset asserted mid-WRITE at i=4 → all outputs return to reset values next cycle, no done pulse. A following start with len=2 completes normally in 6 cycles.

Source files
------------

// File: rtl/onchip_memory_test_master.sv
// onchip_memory_test_master: write/read-back self-test master for the single-port on-chip RAM
module onchip_memory_test_master #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 6500,
   parameter int ERR_W  = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   input  logic [DATA_W-1:0]   seed,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [ERR_W-1:0]    error_count,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic                first_err_valid,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic                m_chipselect,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic                m_clken,
   input  logic [DATA_W-1:0]   m_readdata
);
   typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;
   localparam logic [ADDR_W:0]   DEPTH_N = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   state_t state_q, state_d;
   logic [ADDR_W:0] len_q, len_d, idx_q, idx_d, len_eff, cur_len, cur_idx;
   logic [ADDR_W-1:0] base_q, base_d, ptr_q, ptr_d, base_eff, cur_base, cur_ptr;
   logic [DATA_W-1:0] seed_q, seed_d, cur_seed;
   logic go, go_nz, active, iss, last, miss, fin;
   logic ab_q, ab_d, busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [ADDR_W-1:0] fea_q, fea_d, addr_q, addr_d, pa_q, pa_d;
   logic fev_q, fev_d, cs_q, cs_d, we_q, we_d, pv_q, pv_d;
   logic [DATA_W-1:0] wd_q, wd_d, pe_q, pe_d;
   // The accepted start issues word 0 directly, so IDLE shares the issue path via cur_*
   always_comb begin
      len_eff  = (length > DEPTH_N) ? DEPTH_N : length;
      base_eff = ({1'b0, base_addr} >= DEPTH_N) ? base_addr - DEPTH_N[ADDR_W-1:0] : base_addr;
      go       = state_q == IDLE && start;
      go_nz    = go && len_eff != '0;
      active   = state_q == WRITE || state_q == READ;
      iss      = go_nz || (active && !abort);
      cur_len  = go ? len_eff : len_q;
      cur_idx  = go ? '0 : idx_q;
      cur_base = go ? base_eff : base_q;
      cur_ptr  = go ? base_eff : ptr_q;
      cur_seed = go ? seed : seed_q;
      last     = cur_idx == cur_len - 1'b1;
      miss     = pv_q && m_readdata != pe_q;
      fin      = state_q == FLUSH && !cs_q;
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  state_d = go_nz ? (last ? READ : WRITE) : IDLE;
         WRITE: state_d = abort ? FLUSH : (last ? READ : WRITE);
         READ:  state_d = (abort || last) ? FLUSH : READ;
         FLUSH: state_d = cs_q ? FLUSH : IDLE;
      endcase
   end
   always_comb begin
      len_d     = go ? len_eff : len_q;
      base_d    = go ? base_eff : base_q;
      seed_d    = go ? seed : seed_q;
      idx_d     = iss ? (last ? '0 : cur_idx + 1'b1) : idx_q;
      ptr_d     = iss ? (last ? cur_base : (cur_ptr == LAST ? '0 : cur_ptr + 1'b1)) : ptr_q;
      cs_d      = iss;
      we_d      = iss && (go || state_q == WRITE);
      addr_d    = iss ? cur_ptr : addr_q;
      wd_d      = iss ? cur_seed + DATA_W'(cur_idx) : wd_q;
      // Expected word and address follow the read presented on the bus by one cycle
      pv_d      = cs_q && !we_q;
      pe_d      = wd_q;
      pa_d      = addr_q;
      err_d     = go ? '0 : (miss && !(&err_q)) ? err_q + 1'b1 : err_q;
      fev_d     = go ? 1'b0 : fev_q || miss;
      fea_d     = (miss && !fev_q && !go) ? pa_q : fea_q;
      ab_d      = go ? 1'b0 : ab_q || (active && abort);
      done_d    = (go && !go_nz) || fin;
      aborted_d = fin && ab_q;
      busy_d    = go_nz || (busy_q && !fin);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         base_q    <= '0;
         seed_q    <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wd_q      <= '0;
         pv_q      <= 1'b0;
         pe_q      <= '0;
         pa_q      <= '0;
         err_q     <= '0;
         fev_q     <= 1'b0;
         fea_q     <= '0;
         ab_q      <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         base_q    <= base_d;
         seed_q    <= seed_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         cs_q      <= cs_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wd_q      <= wd_d;
         pv_q      <= pv_d;
         pe_q      <= pe_d;
         pa_q      <= pa_d;
         err_q     <= err_d;
         fev_q     <= fev_d;
         fea_q     <= fea_d;
         ab_q      <= ab_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
         busy_q    <= busy_d;
      end
   end
   assign busy            = busy_q;
   assign done            = done_q;
   assign aborted         = aborted_q;
   assign error_count     = err_q;
   assign first_err_addr  = fea_q;
   assign first_err_valid = fev_q;
   assign m_address       = addr_q;
   assign m_byteenable    = '1;
   assign m_chipselect    = cs_q;
   assign m_write         = we_q;
   assign m_writedata     = wd_q;
   assign m_clken         = 1'b1;
endmodule

// File: tb/tb_onchip_memory_test_master.sv
// tb_onchip_memory_test_master: directed checks against a latency-1 RAM model with injectable bit0 faults
module tb_onchip_memory_test_master;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
   logic [12:0] base_addr = '0;
   logic [13:0] length = '0;
   logic [31:0] seed = '0;
   logic busy, done, aborted, first_err_valid, m_chipselect, m_write, m_clken;
   logic [15:0] error_count;
   logic [12:0] first_err_addr, m_address, ra;
   logic [3:0] m_byteenable;
   logic [31:0] m_writedata, m_readdata, rd;
   logic [31:0] mem [0:6499];
   int fa0 = -1, fa1 = -1;
   int vectors = 0, miscompares = 0;
   logic [12:0] wa [$];
   logic [31:0] wdq [$];

   onchip_memory_test_master dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .seed(seed), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
      .error_count(error_count), .first_err_addr(first_err_addr),
      .first_err_valid(first_err_valid), .m_address(m_address),
      .m_byteenable(m_byteenable), .m_chipselect(m_chipselect), .m_write(m_write),
      .m_writedata(m_writedata), .m_clken(m_clken), .m_readdata(m_readdata)
   );

   always #5 clk = ~clk;

   initial for (int i = 0; i < 6500; i++) mem[i] = '0;

   always @(posedge clk) begin
      if (m_chipselect && m_clken && int'(m_address) < 6500) begin
         if (m_write) mem[m_address] <= m_writedata;
         rd <= mem[m_address];
         ra <= m_address;
      end
   end
   assign m_readdata = rd ^ {31'b0, (int'(ra) == fa0 || int'(ra) == fa1)};

   always @(negedge clk) begin
      if (m_chipselect && m_write) begin
         wa.push_back(m_address);
         wdq.push_back(m_writedata);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_aborted"}, 64'(aborted), 64'd0);
      chk({tag, "_errcnt"}, 64'(error_count), 64'd0);
      chk({tag, "_fea"}, 64'(first_err_addr), 64'd0);
      chk({tag, "_fev"}, 64'(first_err_valid), 64'd0);
      chk({tag, "_cs"}, 64'(m_chipselect), 64'd0);
      chk({tag, "_we"}, 64'(m_write), 64'd0);
      chk({tag, "_addr"}, 64'(m_address), 64'd0);
      chk({tag, "_wd"}, 64'(m_writedata), 64'd0);
      chk({tag, "_be"}, 64'(m_byteenable), 64'hF);
      chk({tag, "_clken"}, 64'(m_clken), 64'd1);
   endtask

   task automatic run(input logic [12:0] b, input logic [13:0] l, input logic [31:0] s,
                      output int lat, output bit busy_seen);
      @(negedge clk);
      base_addr = b; length = l; seed = s; start = 1'b1;
      wa.delete(); wdq.delete();
      @(negedge clk);
      start = 1'b0; lat = 1; busy_seen = busy;
      while (!done && lat < 20000) begin
         @(negedge clk);
         lat++;
         busy_seen |= busy;
      end
   endtask

   initial begin
      int lat, nrd, nw;
      bit bs, fired;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      reset = 1'b0;

      run(13'd0, 14'd16, 32'h1000_0000, lat, bs);
      chk("t1_latency", 64'(lat), 64'd34);
      chk("t1_aborted", 64'(aborted), 64'd0);
      chk("t1_errcnt", 64'(error_count), 64'd0);
      chk("t1_fev", 64'(first_err_valid), 64'd0);
      chk("t1_nwrites", 64'(wa.size()), 64'd16);
      for (int i = 0; i < 16 && i < wa.size(); i++) begin
         chk($sformatf("t1_waddr%0d", i), 64'(wa[i]), 64'(i));
         chk($sformatf("t1_wdata%0d", i), 64'(wdq[i]), 64'(32'h1000_0000 + i));
      end
      @(negedge clk);
      chk("t1_done_pulse", 64'(done), 64'd0);
      chk("t1_busy_after", 64'(busy), 64'd0);

      fa0 = 5;
      run(13'd0, 14'd8, 32'd0, lat, bs);
      chk("t2_latency", 64'(lat), 64'd18);
      chk("t2_errcnt", 64'(error_count), 64'd1);
      chk("t2_fea", 64'(first_err_addr), 64'd5);
      chk("t2_fev", 64'(first_err_valid), 64'd1);
      fa0 = -1;
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t2_retain_err", 64'(error_count), 64'd1);
      chk("t2_retain_fea", 64'(first_err_addr), 64'd5);
      chk("t2_idle_abort", 64'(busy), 64'd0);

      run(13'd6498, 14'd4, 32'd7, lat, bs);
      chk("t3_latency", 64'(lat), 64'd10);
      chk("t3_errcnt", 64'(error_count), 64'd0);
      chk("t3_fev", 64'(first_err_valid), 64'd0);
      chk("t3_nwrites", 64'(wa.size()), 64'd4);
      if (wa.size() == 4) begin
         chk("t3_a0", 64'(wa[0]), 64'd6498);
         chk("t3_a1", 64'(wa[1]), 64'd6499);
         chk("t3_a2", 64'(wa[2]), 64'd0);
         chk("t3_a3", 64'(wa[3]), 64'd1);
         chk("t3_d0", 64'(wdq[0]), 64'd7);
         chk("t3_d3", 64'(wdq[3]), 64'd10);
      end
      chk("t3_mem6499", 64'(mem[6499]), 64'd8);
      chk("t3_mem0", 64'(mem[0]), 64'd9);

      run(13'd0, 14'd0, 32'd3, lat, bs);
      chk("t4_len0_latency", 64'(lat), 64'd1);
      chk("t4_len0_busy", 64'(bs), 64'd0);
      chk("t4_len0_errcnt", 64'(error_count), 64'd0);
      chk("t4_len0_aborted", 64'(aborted), 64'd0);

      run(13'd0, 14'd8000, 32'hA5A5_0000, lat, bs);
      chk("t5_clamp_latency", 64'(lat), 64'd13002);
      chk("t5_clamp_nwrites", 64'(wa.size()), 64'd6500);
      chk("t5_clamp_errcnt", 64'(error_count), 64'd0);
      chk("t5_clamp_mem_last", 64'(mem[6499]), 64'(32'hA5A5_0000 + 6499));

      fa0 = 102; fa1 = 103;
      @(negedge clk);
      base_addr = 13'd100; length = 14'd10; seed = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 1; nrd = 0; fired = 1'b0;
      while (!done && lat < 200) begin
         if (m_chipselect && !m_write) nrd++;
         if (abort) begin
            chk("t6_cs_drop", 64'(m_chipselect), 64'd0);
            abort = 1'b0;
         end else if (nrd == 3 && !fired) begin
            abort = 1'b1;
            fired = 1'b1;
         end
         @(negedge clk);
         lat++;
      end
      abort = 1'b0;
      chk("t6_latency", 64'(lat), 64'd15);
      chk("t6_aborted", 64'(aborted), 64'd1);
      chk("t6_nreads", 64'(nrd), 64'd3);
      chk("t6_errcnt", 64'(error_count), 64'd1);
      chk("t6_fea", 64'(first_err_addr), 64'd102);
      fa0 = -1; fa1 = -1;

      @(negedge clk);
      base_addr = 13'd0; length = 14'd10; seed = 32'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; nw = 0; lat = 0;
      while (nw < 5 && lat < 100) begin
         if (m_chipselect && m_write) nw++;
         if (nw < 5) begin
            @(negedge clk);
            lat++;
         end
      end
      chk("t7_write_i4", 64'(m_address), 64'd4);
      reset = 1'b1;
      @(negedge clk);
      chk_reset("t7_midreset");
      reset = 1'b0;
      run(13'd20, 14'd2, 32'h55, lat, bs);
      chk("t7_latency", 64'(lat), 64'd6);
      chk("t7_errcnt", 64'(error_count), 64'd0);
      chk("t7_aborted", 64'(aborted), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
